blink_receiver: RTL and testbench

- Receive side of the character-blink link: samples an 8-bit character bus that an upstream blinker holds for a fixed number of clocks per character.
- Recovers each character at its mid-point, including back-to-back repeats of the same value.
- Queues recovered characters in a FIFO that the CPU drains through a valid/ready-style pop interface.

---
 rtl/blink_receiver.sv | 116 +++++++++++
 tb/tb_blink_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/blink_receiver.sv
// Receive side of the character-blink link: synchronizes the sender's character bus,
// recovers each held character at its mid-point and queues it in a small FIFO.
module blink_receiver #(
    parameter int char_duration_sec = 1,
    parameter int clk_freq          = 100000000,
    parameter int DEPTH_LOG2        = 4,
    parameter bit IGNORE_ZERO       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            blink_in,
    input  logic                  enable,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    input  logic                  rd_en,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear_ovf
);

    localparam int CHAR_CYCLES = char_duration_sec * clk_freq;
    localparam int SAMPLE_AT   = CHAR_CYCLES / 2;
    localparam int CNT_W       = $clog2(CHAR_CYCLES);
    localparam int DEPTH       = 2 ** DEPTH_LOG2;

    logic [7:0]            sync1;
    logic [7:0]            sync2;
    logic [7:0]            last;
    logic [CNT_W-1:0]      cnt;
    logic                  cap;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  full;
    logic                  pop;
    logic                  do_push;
    logic                  drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= blink_in;
            sync2 <= sync1;
        end
    end

    // The count phase restarts on every value change, so a held value is sampled once
    // per character period, always at the same offset into it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 8'h00;
            cnt  <= '0;
        end else if (sync2 != last) begin
            last <= sync2;
            cnt  <= '0;
        end else if (cnt == CNT_W'(CHAR_CYCLES - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign cap = enable && (sync2 == last) && (cnt == CNT_W'(SAMPLE_AT))
                 && !(IGNORE_ZERO && (last == 8'h00));

    assign full     = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign rd_valid = (count_q != '0);
    assign pop      = rd_en && rd_valid;
    assign do_push  = cap && (!full || pop);
    assign drop     = cap && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({do_push, pop})
                2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign rd_data = rd_valid ? mem[rd_ptr] : 8'h00;
    assign count   = count_q;

endmodule

// File: tb/tb_blink_receiver.sv
// Directed bench for blink_receiver with CHAR_CYCLES=4 (SAMPLE_AT=2) and a 4-entry FIFO.
module tb_blink_receiver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] blink_in;
    logic       enable;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_en;
    logic [2:0] count;
    logic       overflow;
    logic       clear_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] ch;
        int         hold;
        int         idle;
        logic       en;
        logic       rd;
        logic       clr;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_ovf;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    blink_receiver #(
        .char_duration_sec(1),
        .clk_freq(4),
        .DEPTH_LOG2(2),
        .IGNORE_ZERO(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .blink_in(blink_in),
        .enable(enable),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_en(rd_en),
        .count(count),
        .overflow(overflow),
        .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Inputs change only on the falling edge; outputs are read there too.
    task automatic holdFor(input logic [7:0] value, input int n);
        blink_in = value;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkState(input string name, input int exp_count, input logic [7:0] exp_head,
                              input logic exp_ovf);
        checkOutput({name, ".count"}, int'(count), exp_count);
        checkOutput({name, ".valid"}, int'(rd_valid), int'(exp_count != 0));
        checkOutput({name, ".ovf"}, int'(overflow), int'(exp_ovf));
        if (exp_count != 0) begin
            checkOutput({name, ".head"}, int'(rd_data), int'(exp_head));
        end
    endtask

    task automatic popExpect(input string name, input logic [7:0] exp_head);
        checkOutput({name, ".head"}, int'(rd_data), int'(exp_head));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        string name;
        name = $sformatf("vec%0d", idx);
        enable    = v.en;
        rd_en     = v.rd;
        clear_ovf = v.clr;
        holdFor(v.ch, v.hold);
        holdFor(8'h00, v.idle);
        checkState(name, v.exp_count, v.exp_head, v.exp_ovf);
    endtask

    initial begin
        //          ch    hold idle en    rd    clr   cnt head   ovf
        vecs[0]  = '{8'h41, 4, 4, 1'b1, 1'b0, 1'b0, 1, 8'h41, 1'b0};
        vecs[1]  = '{8'h55, 2, 4, 1'b1, 1'b0, 1'b0, 1, 8'h41, 1'b0};
        vecs[2]  = '{8'h55, 3, 4, 1'b1, 1'b0, 1'b0, 1, 8'h41, 1'b0};
        vecs[3]  = '{8'h10, 8, 4, 1'b0, 1'b0, 1'b0, 1, 8'h41, 1'b0};
        vecs[4]  = '{8'h00, 1, 0, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        vecs[5]  = '{8'h00, 4, 0, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        vecs[6]  = '{8'h03, 4, 0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
        vecs[7]  = '{8'h04, 4, 0, 1'b1, 1'b0, 1'b0, 1, 8'h03, 1'b0};
        vecs[8]  = '{8'h05, 4, 4, 1'b1, 1'b0, 1'b0, 3, 8'h03, 1'b0};
        vecs[9]  = '{8'h00, 1, 0, 1'b1, 1'b1, 1'b0, 2, 8'h04, 1'b0};
        vecs[10] = '{8'h00, 1, 0, 1'b1, 1'b1, 1'b0, 1, 8'h05, 1'b0};
        vecs[11] = '{8'h00, 1, 0, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0};
        vecs[12] = '{8'h11, 4, 0, 1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0};
        vecs[13] = '{8'h12, 4, 0, 1'b1, 1'b0, 1'b0, 1, 8'h11, 1'b0};
        vecs[14] = '{8'h13, 4, 0, 1'b1, 1'b0, 1'b0, 2, 8'h11, 1'b0};
        vecs[15] = '{8'h14, 4, 0, 1'b1, 1'b0, 1'b0, 3, 8'h11, 1'b0};
        vecs[16] = '{8'h15, 4, 4, 1'b1, 1'b0, 1'b0, 4, 8'h11, 1'b1};
        vecs[17] = '{8'h00, 1, 0, 1'b1, 1'b0, 1'b1, 4, 8'h11, 1'b0};

        reset_n   = 1'b0;
        blink_in  = 8'h00;
        enable    = 1'b1;
        rd_en     = 1'b0;
        clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        checkState("reset", 0, 8'h00, 1'b0);
        checkOutput("reset.data", int'(rd_data), 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i, vecs[i]);
        end
        rd_en     = 1'b0;
        clear_ovf = 1'b0;
        enable    = 1'b1;

        // Drop and clear on the same edge: the drop wins.
        holdFor(8'h16, 4);
        holdFor(8'h00, 1);
        clear_ovf = 1'b1;
        holdFor(8'h00, 1);
        clear_ovf = 1'b0;
        checkState("setwins", 4, 8'h11, 1'b1);
        clear_ovf = 1'b1;
        holdFor(8'h00, 1);
        clear_ovf = 1'b0;
        checkState("clear", 4, 8'h11, 1'b0);

        // Push and pop on the same edge while full.
        holdFor(8'h17, 4);
        holdFor(8'h00, 1);
        rd_en = 1'b1;
        holdFor(8'h00, 1);
        rd_en = 1'b0;
        checkState("fullpp", 4, 8'h12, 1'b0);
        popExpect("drain0", 8'h12);
        popExpect("drain1", 8'h13);
        popExpect("drain2", 8'h14);
        popExpect("drain3", 8'h17);
        checkState("drained", 0, 8'h00, 1'b0);

        // A held character repeats every 4 edges, first capture at edge 6.
        for (int e = 1; e <= 16; e++) begin
            blink_in = (e <= 12) ? 8'h42 : 8'h00;
            @(negedge clk);
            checkOutput($sformatf("repeat.e%0d", e), int'(count),
                        int'(e >= 6) + int'(e >= 10) + int'(e >= 14));
        end
        popExpect("rep0", 8'h42);
        popExpect("rep1", 8'h42);
        popExpect("rep2", 8'h42);

        // Push and pop on the same edge with one entry queued.
        holdFor(8'hA1, 4);
        holdFor(8'h00, 4);
        holdFor(8'hA2, 4);
        holdFor(8'h00, 1);
        checkState("pp.pre", 1, 8'hA1, 1'b0);
        rd_en = 1'b1;
        holdFor(8'h00, 1);
        rd_en = 1'b0;
        checkState("pp.post", 1, 8'hA2, 1'b0);
        popExpect("pp.pop", 8'hA2);

        // Re-enabling mid-character captures at the next sample point (edge 10).
        enable   = 1'b0;
        holdFor(8'h20, 6);
        checkState("reen.off", 0, 8'h00, 1'b0);
        enable = 1'b1;
        holdFor(8'h20, 2);
        holdFor(8'h00, 1);
        checkState("reen.e9", 0, 8'h00, 1'b0);
        holdFor(8'h00, 1);
        checkState("reen.e10", 1, 8'h20, 1'b0);

        holdFor(8'h21, 4);
        holdFor(8'h00, 4);
        holdFor(8'h22, 4);
        holdFor(8'h00, 4);
        checkState("prereset", 3, 8'h20, 1'b0);

        // Asynchronous reset between clock edges.
        #1 reset_n = 1'b0;
        #1;
        checkOutput("asyncrst.count", int'(count), 0);
        checkOutput("asyncrst.valid", int'(rd_valid), 0);
        blink_in = 8'h61;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            blink_in = (e <= 4) ? 8'h61 : 8'h00;
            @(negedge clk);
            checkOutput($sformatf("postrst.e%0d", e), int'(count), int'(e >= 6));
        end
        checkState("postrst", 1, 8'h61, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
